// File: rtl/isqrt_shared_arbiter.sv
// isqrt_shared_arbiter
// Shares one fixed-latency, in-order isqrt pipeline among N_REQ requesters.
// Round-robin arbitration with per-requester credits, an in-order tag FIFO
// holding the requester ID of every issued operand, and one show-ahead result
// FIFO per requester.
//
// Handshakes: a request transfers on a cycle where req_vld[i] & req_rdy[i];
// req_rdy is a one-hot grant that never asserts without req_vld and may drop
// at any time. A result transfers on a cycle where out_vld[i] & out_rdy[i];
// out_vld stays high and out_y stays stable until that transfer.
// The isqrt side is valid-only: isqrt_y_vld cannot be stalled.
module isqrt_shared_arbiter #(
  parameter int N_REQ     = 3,
  parameter int X_W       = 32,
  parameter int ISQRT_LAT = 16,
  parameter int RES_DEPTH = 4,
  parameter int TAG_DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ*X_W-1:0]        req_x,
  output logic [N_REQ-1:0]            req_rdy,
  output logic [N_REQ-1:0]            out_vld,
  output logic [N_REQ*(X_W/2)-1:0]    out_y,
  input  logic [N_REQ-1:0]            out_rdy,
  output logic                        isqrt_x_vld,
  output logic [X_W-1:0]              isqrt_x,
  input  logic                        isqrt_y_vld,
  input  logic [X_W/2-1:0]            isqrt_y,
  output logic                        err
);

  localparam int Y_W   = X_W / 2;
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CR_W  = $clog2(RES_DEPTH + 1);
  localparam int RP_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int RC_W  = $clog2(RES_DEPTH + 1);
  // The tag FIFO is never shallower than a full pipeline plus the issue and
  // return registers, so a legal configuration can never fill it.
  localparam int TAG_D = (TAG_DEPTH > ISQRT_LAT + 2) ? TAG_DEPTH : ISQRT_LAT + 2;
  localparam int TP_W  = $clog2(TAG_D);
  localparam int TC_W  = $clog2(TAG_D + 1);

  // Arbitration state and issue register
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_x_vld;
  logic [X_W-1:0]   r_x;
  logic             r_err;

  // Tag FIFO
  logic [ID_W-1:0]  r_tag_mem [TAG_D];
  logic [TP_W-1:0]  r_tag_wp;
  logic [TP_W-1:0]  r_tag_rp;
  logic [TC_W-1:0]  r_tag_cnt;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_gidx;
  logic             w_gnt_any;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic             w_tag_push;
  logic             w_tag_pop;
  logic [ID_W-1:0]  w_tag_head;

  assign w_tag_full  = (r_tag_cnt == TC_W'(TAG_D));
  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_tag_push  = w_gnt_any && !w_tag_full;
  assign w_tag_pop   = isqrt_y_vld && !w_tag_empty;
  assign w_tag_head  = r_tag_mem[r_tag_rp];

  assign req_rdy     = w_grant;
  assign isqrt_x_vld = r_x_vld;
  assign isqrt_x     = r_x;
  assign err         = r_err;

  // Round-robin search: first eligible index starting at r_rr_ptr
  always_comb begin
    int idx;
    w_grant   = '0;
    w_gidx    = '0;
    w_gnt_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_gnt_any && w_elig[idx]) begin
        w_gnt_any    = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = ID_W'(idx);
      end
    end
  end

  // Pointer rotation and the registered issue port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_x_vld  <= 1'b0;
      r_x      <= '0;
    end else begin
      r_x_vld <= w_gnt_any;
      if (w_gnt_any) begin
        r_rr_ptr <= (w_gidx == ID_W'(N_REQ - 1)) ? '0 : w_gidx + ID_W'(1);
        r_x      <= req_x[w_gidx*X_W +: X_W];
      end
    end
  end

  // Tag FIFO: push the granted ID, pop on every returning result; sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_wp  <= '0;
      r_tag_rp  <= '0;
      r_tag_cnt <= '0;
      r_err     <= 1'b0;
      for (int k = 0; k < TAG_D; k++) r_tag_mem[k] <= '0;
    end else begin
      if (w_gnt_any && w_tag_full) r_err <= 1'b1;
      if (isqrt_y_vld && w_tag_empty) r_err <= 1'b1;
      if (w_tag_push) begin
        r_tag_mem[r_tag_wp] <= w_gidx;
        r_tag_wp <= (r_tag_wp == TP_W'(TAG_D - 1)) ? '0 : r_tag_wp + TP_W'(1);
      end
      if (w_tag_pop) begin
        r_tag_rp <= (r_tag_rp == TP_W'(TAG_D - 1)) ? '0 : r_tag_rp + TP_W'(1);
      end
      case ({w_tag_push, w_tag_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + TC_W'(1);
        2'b01:   r_tag_cnt <= r_tag_cnt - TC_W'(1);
        default: r_tag_cnt <= r_tag_cnt;
      endcase
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    logic [CR_W-1:0] r_credit;
    logic [Y_W-1:0]  r_mem [RES_DEPTH];
    logic [RP_W-1:0] r_wp;
    logic [RP_W-1:0] r_rp;
    logic [RC_W-1:0] r_cnt;
    logic            w_wr;
    logic            w_pop;

    // Credits guarantee space; the occupancy guard only protects against misuse
    assign w_wr        = w_tag_pop && (w_tag_head == ID_W'(i)) && (r_cnt != RC_W'(RES_DEPTH));
    assign w_pop       = (r_cnt != '0) && out_rdy[i];
    assign out_vld[i]  = (r_cnt != '0);
    assign out_y[i*Y_W +: Y_W] = r_mem[r_rp];
    assign w_elig[i]   = req_vld[i] && (r_credit != '0) && !w_tag_full;

    // One credit per free result slot: spent on grant, returned on pop
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_credit <= CR_W'(RES_DEPTH);
      end else begin
        case ({w_grant[i], w_pop})
          2'b10: r_credit <= r_credit - CR_W'(1);
          2'b01: if (r_credit != CR_W'(RES_DEPTH)) r_credit <= r_credit + CR_W'(1);
          default: r_credit <= r_credit;
        endcase
      end
    end

    // Show-ahead result FIFO for this requester
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        for (int k = 0; k < RES_DEPTH; k++) r_mem[k] <= '0;
      end else begin
        if (w_wr) begin
          r_mem[r_wp] <= isqrt_y;
          r_wp <= (r_wp == RP_W'(RES_DEPTH - 1)) ? '0 : r_wp + RP_W'(1);
        end
        if (w_pop) begin
          r_rp <= (r_rp == RP_W'(RES_DEPTH - 1)) ? '0 : r_rp + RP_W'(1);
        end
        case ({w_wr, w_pop})
          2'b10:   r_cnt <= r_cnt + RC_W'(1);
          2'b01:   r_cnt <= r_cnt - RC_W'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Bench for isqrt_shared_arbiter: a behavioural isqrt pipeline, a per-requester
// expected-result scoreboard, a vector table and hand-written corner sequences.
module tb_isqrt_shared_arbiter;

  localparam int N   = 3;
  localparam int XW  = 32;
  localparam int YW  = 16;
  localparam int LAT = 16;
  localparam int RD  = 4;
  localparam int TD  = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_vld;
  logic [N*XW-1:0]   req_x;
  logic [N-1:0]      req_rdy;
  logic [N-1:0]      out_vld;
  logic [N*YW-1:0]   out_y;
  logic [N-1:0]      out_rdy;
  logic              isqrt_x_vld;
  logic [XW-1:0]     isqrt_x;
  logic              isqrt_y_vld;
  logic [YW-1:0]     isqrt_y;
  logic              err;

  isqrt_shared_arbiter #(
    .N_REQ(N), .X_W(XW), .ISQRT_LAT(LAT), .RES_DEPTH(RD), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .out_vld(out_vld), .out_y(out_y), .out_rdy(out_rdy),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference isqrt ----------------
  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    logic [31:0] sq;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t  = r | (16'(1) << b);
      sq = 32'(t) * 32'(t);
      if (sq <= x) r = t;
    end
    return r;
  endfunction

  // Behavioural isqrt unit: fixed latency LAT, shares rst_n, plus stray-pulse injection
  logic [LAT-1:0] m_vld;
  logic [YW-1:0]  m_y [LAT];
  logic           inj;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      for (int k = 0; k < LAT; k++) m_y[k] <= '0;
    end else begin
      m_vld  <= {m_vld[LAT-2:0], isqrt_x_vld};
      m_y[0] <= isqrt_ref(isqrt_x);
      for (int k = 1; k < LAT; k++) m_y[k] <= m_y[k-1];
    end
  end

  assign isqrt_y_vld = m_vld[LAT-1] | inj;
  assign isqrt_y     = m_y[LAT-1];

  // ---------------- scoreboard ----------------
  logic [YW-1:0] exp_q0[$];
  logic [YW-1:0] exp_q1[$];
  logic [YW-1:0] exp_q2[$];

  function automatic void q_push(input int i, input logic [YW-1:0] v);
    case (i)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic logic [YW-1:0] q_pop(input int i);
    case (i)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  logic [YW-1:0] drv_exp [N];
  logic [N-1:0]  granted_last;
  int            gcnt [N];
  logic          prev_gvld;
  logic [XW-1:0] prev_gx;
  logic          chk_rot;
  logic          rot_first;
  int            rot_exp;

  // Monitor: handshake legality, issue register, result compare, grant capture
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      prev_gvld    = 1'b0;
      granted_last = '0;
    end else begin
      check("rdy_onehot_legal",
            64'($onehot0(req_rdy) && ((req_rdy & ~req_vld) == '0)), 64'd1);
      check("issue_vld", 64'(isqrt_x_vld), 64'(prev_gvld));
      if (prev_gvld) check("issue_x", 64'(isqrt_x), 64'(prev_gx));
      for (int i = 0; i < N; i++) begin
        if (out_vld[i] && out_rdy[i]) begin
          if (q_size(i) == 0) check($sformatf("spurious_out%0d", i), 64'd1, 64'd0);
          else check($sformatf("out_y%0d", i), 64'(out_y[i*YW +: YW]), 64'(q_pop(i)));
        end
      end
      prev_gvld    = 1'b0;
      granted_last = '0;
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          prev_gvld       = 1'b1;
          prev_gx         = req_x[i*XW +: XW];
          granted_last[i] = 1'b1;
          gcnt[i]++;
          q_push(i, drv_exp[i]);
          if (chk_rot) begin
            if (!rot_first) check("rr_order", 64'(i), 64'(rot_exp));
            rot_first = 1'b0;
            rot_exp   = (i + 1) % N;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int k_idx [N];

  task automatic set_x(input int i);
    logic [XW-1:0] x;
    x = XW'(i * i + 100 * k_idx[i]);
    req_x[i*XW +: XW] = x;
    drv_exp[i] = isqrt_ref(x);
  endtask

  // Single transfer from requester id, bounded wait for its grant
  task automatic send(input int id, input logic [XW-1:0] x, input logic [YW-1:0] y);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_x[id*XW +: XW] = x;
    drv_exp[id] = y;
    req_vld[id] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_rdy[id]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_vld[id] = 1'b0;
  endtask

  // Continuous stream: masked requesters keep a fresh operand each cycle
  task automatic stream(input int ncyc, input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      k_idx[i] = 0;
      set_x(i);
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (granted_last[i]) begin
          k_idx[i]++;
          set_x(i);
        end
      end
      req_vld = mask;
    end
    @(posedge clk); #1;
    req_vld = '0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_rdy = '1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (q_size(0) == 0 && q_size(1) == 0 && q_size(2) == 0 && out_vld == '0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            id;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } vec_t;

  vec_t vecs [12];

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    bit others;

    vecs[0]  = '{0, 32'd0,          16'd0};
    vecs[1]  = '{1, 32'd1,          16'd1};
    vecs[2]  = '{2, 32'hFFFF_FFFF,  16'hFFFF};
    vecs[3]  = '{0, 32'd2,          16'd1};
    vecs[4]  = '{1, 32'd3,          16'd1};
    vecs[5]  = '{2, 32'd4,          16'd2};
    vecs[6]  = '{0, 32'd99,         16'd9};
    vecs[7]  = '{1, 32'd100,        16'd10};
    vecs[8]  = '{2, 32'd65535,      16'd255};
    vecs[9]  = '{0, 32'd65536,      16'd256};
    vecs[10] = '{1, 32'hFFFE_0001,  16'hFFFF};
    vecs[11] = '{2, 32'hFFFE_0000,  16'hFFFE};

    rst_n   = 1'b0;
    req_vld = '0;
    req_x   = '0;
    out_rdy = '0;
    inj     = 1'b0;
    chk_rot = 1'b0;
    rot_first = 1'b1;
    rot_exp = 0;
    for (int i = 0; i < N; i++) begin
      gcnt[i] = 0;
      k_idx[i] = 0;
      drv_exp[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_x_vld",   64'(isqrt_x_vld), 64'd0);
    check("rst_x",       64'(isqrt_x),     64'd0);
    check("rst_err",     64'(err),         64'd0);
    check("rst_out_vld", 64'(out_vld),     64'd0);
    check("rst_req_rdy", 64'(req_rdy),     64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single op from requester 1, latency check
    out_rdy = '1;
    send(1, 32'd144, 16'd12);
    lat = 0;
    others = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("single_x_vld", 64'(isqrt_x_vld), 64'd1);
        check("single_x",     64'(isqrt_x),     64'd144);
      end
      if (out_vld[0] || out_vld[2]) others = 1'b1;
      if (out_vld[1]) begin
        lat = c;
        break;
      end
    end
    check("single_latency", 64'(lat), 64'd18);
    check("single_others_idle", 64'(others), 64'd0);
    drain();

    // Table of operand/result pairs including boundaries
    for (int j = 0; j < 12; j++) send(vecs[j].id, vecs[j].x, vecs[j].y);
    drain();
    check("table_err", 64'(err), 64'd0);

    // All requesters streaming, consumers ready: strict rotation, fair share
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    rot_first = 1'b1;
    chk_rot = 1'b1;
    stream(45, 3'b111);
    chk_rot = 1'b0;
    check("share_01", 64'((gcnt[0] - gcnt[1] <= 1) && (gcnt[1] - gcnt[0] <= 1)), 64'd1);
    check("share_12", 64'((gcnt[1] - gcnt[2] <= 1) && (gcnt[2] - gcnt[1] <= 1)), 64'd1);
    drain();

    // Consumer 0 stalled: exactly RES_DEPTH grants to requester 0
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    out_rdy = 3'b110;
    stream(60, 3'b111);
    check("stall_grants0", 64'(gcnt[0]), 64'(RD));
    check("stall_grants1", 64'(gcnt[1] >= 8), 64'd1);
    check("stall_grants2", 64'(gcnt[2] >= 8), 64'd1);
    check("stall_rdy0", 64'(req_rdy[0]), 64'd0);
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    out_rdy = 3'b111;
    stream(40, 3'b111);
    check("resume_grants0", 64'(gcnt[0] >= 4), 64'd1);
    drain();

    // Same-cycle grant and pop on requester 0 leaves its credit at 1
    out_rdy = 3'b110;
    stream(3, 3'b001);
    repeat (25) @(posedge clk);
    #1;
    k_idx[0] = 50;
    set_x(0);
    req_vld = 3'b001;
    out_rdy = 3'b111;
    @(negedge clk);
    check("same_cycle_grant", 64'(req_rdy[0]), 64'd1);
    check("same_cycle_pop",   64'(out_vld[0]), 64'd1);
    @(posedge clk); #1;
    req_vld = '0;
    out_rdy = 3'b110;
    gcnt[0] = 0;
    stream(6, 3'b001);
    check("credit_after_same_cycle", 64'(gcnt[0]), 64'd1);
    drain();

    // Stray isqrt result with nothing issued
    @(posedge clk); #1;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    check("stray_err_set", 64'(err), 64'd1);
    check("stray_no_out",  64'(out_vld), 64'd0);
    repeat (5) @(negedge clk);
    check("stray_err_sticky", 64'(err), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("stray_err_cleared", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset with 10 operations in flight
    out_rdy = '1;
    stream(10, 3'b111);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_x_vld",   64'(isqrt_x_vld), 64'd0);
    check("mid_rst_x",       64'(isqrt_x),     64'd0);
    check("mid_rst_err",     64'(err),         64'd0);
    check("mid_rst_out_vld", 64'(out_vld),     64'd0);
    check("mid_rst_out_y",   64'(out_y),       64'd0);
    check("mid_rst_req_rdy", 64'(req_rdy),     64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    out_rdy = '0;
    stream(25, 3'b111);
    check("post_rst_credit0", 64'(gcnt[0]), 64'(RD));
    check("post_rst_credit1", 64'(gcnt[1]), 64'(RD));
    check("post_rst_credit2", 64'(gcnt[2]), 64'(RD));
    drain();
    check("post_rst_err", 64'(err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
